vp_block_receiver: RTL and testbench

Wishbone-side responder inside each vector processor (VP) that terminates block transfers issued by the memory controller. It ACKs each 32-bit beat, packs two beats into one 64-bit code-memory word or three beats into one 96-bit data-memory word, and emits a single-cycle write strobe to the VP's code or data memory. It is the slave end of the controller's `DAT/ADR/STB/WE/TAG/CYC/MST/ACK` bus and is instantiated once per core.

---
 rtl/vp_block_receiver_pkg.sv | 29 ++
 rtl/vp_block_receiver_assembler.sv | 51 +++++
 rtl/vp_block_receiver.sv | 189 ++++++++++++++++++
 tb/tb_vp_block_receiver.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_block_receiver_pkg.sv
// Shared definitions for the VP block receiver: bus width, transfer tags,
// receiver FSM encodings and beat counts per memory word.
package vp_block_receiver_pkg;

    localparam int WB_WIDTH = 32;

    localparam logic [1:0] TAG_INSTRUCTION_ADDRESS_TYPE = 2'b01;
    localparam logic [1:0] TAG_DATA_ADDRESS_TYPE        = 2'b10;

    localparam logic [1:0] VPRX_STATE_IDLE     = 2'd0;
    localparam logic [1:0] VPRX_STATE_COLLECT  = 2'd1;
    localparam logic [1:0] VPRX_STATE_WAIT_END = 2'd2;
    localparam logic [1:0] VPRX_STATE_DISCARD  = 2'd3;

    localparam logic [1:0] VPRX_CODE_BEATS = 2'd2;
    localparam logic [1:0] VPRX_DATA_BEATS = 2'd3;

    // Zero means the tag is not a legal block type.
    function automatic logic [1:0] beats_for_tag(input logic [1:0] tag);
        logic [1:0] beats;
        case (tag)
            TAG_INSTRUCTION_ADDRESS_TYPE: beats = VPRX_CODE_BEATS;
            TAG_DATA_ADDRESS_TYPE:        beats = VPRX_DATA_BEATS;
            default:                      beats = 2'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/vp_block_receiver_assembler.sv
// Beat assembler: 96-bit left-shift register plus beat counter. The first
// beat ends up in the most significant occupied slot.
module vp_beat_assembler
    import vp_block_receiver_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                load,
    input  logic [WB_WIDTH-1:0] din,
    output logic [95:0]         word,
    output logic [95:0]         next_word,
    output logic [1:0]          count
);

    logic [95:0] word_q, word_d;
    logic [1:0]  count_q, count_d;

    assign next_word = {word_q[63:0], din};

    // Shift / clear next-state logic
    always_comb begin
        word_d  = word_q;
        count_d = count_q;
        if (clr) begin
            word_d  = 96'd0;
            count_d = 2'd0;
        end else if (load) begin
            word_d  = next_word;
            count_d = count_q + 2'd1;
        end else begin
            word_d  = word_q;
            count_d = count_q;
        end
    end

    // Assembler state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= 96'd0;
            count_q <= 2'd0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

    assign word  = word_q;
    assign count = count_q;

endmodule

// File: rtl/vp_block_receiver.sv
// Wishbone-side block-transfer responder: ACKs 32-bit beats and packs them into
// 64-bit code words or 96-bit data words with a one-cycle write strobe.
module vp_block_receiver
    import vp_block_receiver_pkg::*;
#(
    parameter int CODE_ADDR_WIDTH = 16,
    parameter int DATA_ADDR_WIDTH = 16
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [WB_WIDTH-1:0]        DAT_I,
    input  logic [WB_WIDTH-1:0]        ADR_I,
    input  logic                       STB_I,
    input  logic                       WE_I,
    input  logic [1:0]                 TAG_I,
    input  logic                       CYC_I,
    input  logic                       MST_I,
    output logic                       ACK_O,
    output logic                       oCodeWriteEnable,
    output logic [CODE_ADDR_WIDTH-1:0] oCodeAddress,
    output logic [63:0]                oCodeData,
    output logic                       oDataWriteEnable,
    output logic [DATA_ADDR_WIDTH-1:0] oDataAddress,
    output logic [95:0]                oDataData,
    output logic                       oBusy,
    output logic                       oProtocolError
);

    logic [1:0]                 state_q, state_d;
    logic [1:0]                 target_q, target_d;
    logic [WB_WIDTH-1:0]        adr_q, adr_d;
    logic                       ack_q, ack_d;
    logic                       code_we_q, code_we_d;
    logic [CODE_ADDR_WIDTH-1:0] code_addr_q, code_addr_d;
    logic [63:0]                code_data_q, code_data_d;
    logic                       data_we_q, data_we_d;
    logic [DATA_ADDR_WIDTH-1:0] data_addr_q, data_addr_d;
    logic [95:0]                data_data_q, data_data_d;
    logic                       busy_q, busy_d;
    logic                       err_q, err_d;

    logic        sel_s, accept_s, asm_clr_s, asm_load_s;
    logic [1:0]  asm_count_s;
    logic [95:0] asm_word_s, asm_next_s;
    logic        unused_s;

    // MST_I is informational; ADR_I is only partially consumed.
    assign unused_s = ^{MST_I, ADR_I, asm_word_s};

    assign sel_s    = CYC_I & WE_I;
    assign accept_s = STB_I & ~ack_q & sel_s;

    vp_beat_assembler u_asm (
        .clk       (Clock),
        .rst_n     (Reset),
        .clr       (asm_clr_s),
        .load      (asm_load_s),
        .din       (DAT_I),
        .word      (asm_word_s),
        .next_word (asm_next_s),
        .count     (asm_count_s)
    );

    // Receiver FSM and output next-state logic
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        adr_d       = adr_q;
        ack_d       = 1'b0;
        code_we_d   = 1'b0;
        code_addr_d = code_addr_q;
        code_data_d = code_data_q;
        data_we_d   = 1'b0;
        data_addr_d = data_addr_q;
        data_data_d = data_data_q;
        err_d       = err_q;
        asm_clr_s   = 1'b0;
        asm_load_s  = 1'b0;
        case (state_q)
            VPRX_STATE_IDLE: begin
                if (sel_s) begin
                    adr_d     = ADR_I;
                    asm_clr_s = 1'b1;
                    target_d  = beats_for_tag(TAG_I);
                    if (beats_for_tag(TAG_I) == 2'd0) begin
                        err_d   = 1'b1;
                        state_d = VPRX_STATE_DISCARD;
                    end else begin
                        state_d = VPRX_STATE_COLLECT;
                    end
                end else begin
                    state_d = VPRX_STATE_IDLE;
                end
            end
            VPRX_STATE_COLLECT: begin
                if (!sel_s) begin
                    // Block ended short: partial word is dropped.
                    err_d     = 1'b1;
                    asm_clr_s = 1'b1;
                    state_d   = VPRX_STATE_IDLE;
                end else if (accept_s) begin
                    asm_load_s = 1'b1;
                    ack_d      = 1'b1;
                    if ((asm_count_s + 2'd1) == target_q) begin
                        state_d = VPRX_STATE_WAIT_END;
                        if (target_q == VPRX_CODE_BEATS) begin
                            code_we_d   = 1'b1;
                            code_addr_d = adr_q[CODE_ADDR_WIDTH-1:0];
                            code_data_d = asm_next_s[63:0];
                        end else begin
                            data_we_d   = 1'b1;
                            data_addr_d = adr_q[DATA_ADDR_WIDTH-1:0];
                            data_data_d = asm_next_s;
                        end
                    end else begin
                        state_d = VPRX_STATE_COLLECT;
                    end
                end else begin
                    state_d = VPRX_STATE_COLLECT;
                end
            end
            VPRX_STATE_WAIT_END: begin
                if (!CYC_I) begin
                    state_d = VPRX_STATE_IDLE;
                end else if (accept_s) begin
                    ack_d = 1'b1;
                    err_d = 1'b1;
                end else begin
                    state_d = VPRX_STATE_WAIT_END;
                end
            end
            VPRX_STATE_DISCARD: begin
                if (!CYC_I) begin
                    state_d = VPRX_STATE_IDLE;
                end else if (accept_s) begin
                    ack_d = 1'b1;
                end else begin
                    state_d = VPRX_STATE_DISCARD;
                end
            end
            default: begin
                state_d = VPRX_STATE_IDLE;
            end
        endcase
        busy_d = (state_d != VPRX_STATE_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= VPRX_STATE_IDLE;
            target_q    <= 2'd0;
            adr_q       <= '0;
            ack_q       <= 1'b0;
            code_we_q   <= 1'b0;
            code_addr_q <= '0;
            code_data_q <= 64'd0;
            data_we_q   <= 1'b0;
            data_addr_q <= '0;
            data_data_q <= 96'd0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            adr_q       <= adr_d;
            ack_q       <= ack_d;
            code_we_q   <= code_we_d;
            code_addr_q <= code_addr_d;
            code_data_q <= code_data_d;
            data_we_q   <= data_we_d;
            data_addr_q <= data_addr_d;
            data_data_q <= data_data_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign ACK_O            = ack_q;
    assign oCodeWriteEnable = code_we_q;
    assign oCodeAddress     = code_addr_q;
    assign oCodeData        = code_data_q;
    assign oDataWriteEnable = data_we_q;
    assign oDataAddress     = data_addr_q;
    assign oDataData        = data_data_q;
    assign oBusy            = busy_q;
    assign oProtocolError   = err_q;

endmodule

// File: tb/tb_vp_block_receiver.sv
// Self-checking bench for vp_block_receiver: a bus master drives blocks and a
// scoreboard of expected memory writes is checked every cycle.
module tb_vp_block_receiver;
    import vp_block_receiver_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] DAT_I = 32'd0;
    logic [31:0] ADR_I = 32'd0;
    logic        STB_I = 1'b0;
    logic        WE_I  = 1'b0;
    logic [1:0]  TAG_I = 2'd0;
    logic        CYC_I = 1'b0;
    logic        MST_I = 1'b0;
    logic        ACK_O;
    logic        oCodeWriteEnable;
    logic [15:0] oCodeAddress;
    logic [63:0] oCodeData;
    logic        oDataWriteEnable;
    logic [15:0] oDataAddress;
    logic [95:0] oDataData;
    logic        oBusy;
    logic        oProtocolError;

    typedef struct {
        logic        is_code;
        logic [15:0] addr;
        logic [95:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  ack_cnt = 0;

    always #5 Clock = ~Clock;

    vp_block_receiver dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .DAT_I            (DAT_I),
        .ADR_I            (ADR_I),
        .STB_I            (STB_I),
        .WE_I             (WE_I),
        .TAG_I            (TAG_I),
        .CYC_I            (CYC_I),
        .MST_I            (MST_I),
        .ACK_O            (ACK_O),
        .oCodeWriteEnable (oCodeWriteEnable),
        .oCodeAddress     (oCodeAddress),
        .oCodeData        (oCodeData),
        .oDataWriteEnable (oDataWriteEnable),
        .oDataAddress     (oDataAddress),
        .oDataData        (oDataData),
        .oBusy            (oBusy),
        .oProtocolError   (oProtocolError)
    );

    // Advance to the next falling edge and check any write against the scoreboard.
    task automatic step();
        wr_t e;
        @(negedge Clock);
        if (ACK_O === 1'b1) ack_cnt++;
        tests++;
        if ((oCodeWriteEnable & oDataWriteEnable) !== 1'b0) begin
            fails++;
            $display("FAIL we_exclusive: code=%b data=%b, required not both high", oCodeWriteEnable, oDataWriteEnable);
        end
        if (oCodeWriteEnable === 1'b1 || oDataWriteEnable === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: code_we=%b data_we=%b, required no write", oCodeWriteEnable, oDataWriteEnable);
            end else begin
                e = exp_q.pop_front();
                if (oCodeWriteEnable !== e.is_code || ACK_O !== 1'b1) begin
                    fails++;
                    $display("FAIL write_kind: code_we=%b ack=%b, required code_we=%b ack=1", oCodeWriteEnable, ACK_O, e.is_code);
                end else if (e.is_code && (oCodeAddress !== e.addr || oCodeData !== e.data[63:0])) begin
                    fails++;
                    $display("FAIL code_write: addr=%h data=%h, required addr=%h data=%h", oCodeAddress, oCodeData, e.addr, e.data[63:0]);
                end else if (!e.is_code && (oDataAddress !== e.addr || oDataData !== e.data)) begin
                    fails++;
                    $display("FAIL data_write: addr=%h data=%h, required addr=%h data=%h", oDataAddress, oDataData, e.addr, e.data);
                end
            end
        end
    endtask

    // Drive one block of n beats (n may be short of the tag's target to force an abort).
    task automatic send_block(input logic [1:0] tag, input logic [31:0] adr,
                              input logic [31:0] b0, input logic [31:0] b1,
                              input logic [31:0] b2, input int n);
        logic [31:0] beats [3];
        bit          got;
        beats[0] = b0; beats[1] = b1; beats[2] = b2;
        CYC_I = 1'b1; WE_I = 1'b1; TAG_I = tag; ADR_I = adr; MST_I = 1'b1;
        for (int b = 0; b < n; b++) begin
            DAT_I = beats[b];
            STB_I = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                step();
                if (ACK_O === 1'b1) got = 1'b1;
            end
            if (!got) begin
                tests++;
                fails++;
                $display("FAIL ack_timeout: beat %0d got no ACK within 20 cycles, required ACK", b);
            end
        end
        STB_I = 1'b0;
        step();
        CYC_I = 1'b0; WE_I = 1'b0; MST_I = 1'b0;
        step();
    endtask

    task automatic push(input logic is_code, input logic [15:0] addr, input logic [95:0] data);
        wr_t e;
        e.is_code = is_code; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        step();
        tests++;
        if ({ACK_O, oCodeWriteEnable, oDataWriteEnable, oBusy, oProtocolError} !== 5'b0 ||
            oCodeAddress !== 16'd0 || oCodeData !== 64'd0 || oDataAddress !== 16'd0 || oDataData !== 96'd0) begin
            fails++;
            $display("FAIL reset_state: ack=%b cwe=%b dwe=%b busy=%b err=%b, required all zero",
                     ACK_O, oCodeWriteEnable, oDataWriteEnable, oBusy, oProtocolError);
        end
        Reset = 1'b1;
        step();
    endtask

    task automatic test_code_block();
        push(1'b1, 16'h0010, {32'd0, 64'hAAAA0001_BBBB0002});
        ack_cnt = 0;
        send_block(TAG_INSTRUCTION_ADDRESS_TYPE, 32'h10, 32'hAAAA0001, 32'hBBBB0002, 32'd0, 2);
        tests++;
        if (ack_cnt !== 2 || exp_q.size() !== 0) begin
            fails++;
            $display("FAIL code_block: acks=%0d pending=%0d, required acks=2 pending=0", ack_cnt, exp_q.size());
        end
        tests++;
        if (oProtocolError !== 1'b0 || oBusy !== 1'b0 || oDataWriteEnable !== 1'b0) begin
            fails++;
            $display("FAIL code_block_flags: err=%b busy=%b dwe=%b, required 0 0 0", oProtocolError, oBusy, oDataWriteEnable);
        end
    endtask

    task automatic test_data_block();
        push(1'b0, 16'h0022, 96'h00000001_00000002_00000003);
        ack_cnt = 0;
        send_block(TAG_DATA_ADDRESS_TYPE, 32'h22, 32'h1, 32'h2, 32'h3, 3);
        tests++;
        if (ack_cnt !== 3 || exp_q.size() !== 0 || oProtocolError !== 1'b0) begin
            fails++;
            $display("FAIL data_block: acks=%0d pending=%0d err=%b, required 3 0 0", ack_cnt, exp_q.size(), oProtocolError);
        end
    endtask

    task automatic test_back_to_back();
        push(1'b1, 16'h0010, {32'd0, 64'h11111111_22222222});
        push(1'b1, 16'h0011, {32'd0, 64'h33333333_44444444});
        send_block(TAG_INSTRUCTION_ADDRESS_TYPE, 32'h10, 32'h11111111, 32'h22222222, 32'd0, 2);
        send_block(TAG_INSTRUCTION_ADDRESS_TYPE, 32'h11, 32'h33333333, 32'h44444444, 32'd0, 2);
        tests++;
        if (exp_q.size() !== 0 || oProtocolError !== 1'b0) begin
            fails++;
            $display("FAIL back_to_back: pending=%0d err=%b, required 0 0", exp_q.size(), oProtocolError);
        end
        tests++;
        if (oCodeAddress !== 16'h0011 || oDataAddress !== 16'h0022 || oDataData !== 96'h00000001_00000002_00000003) begin
            fails++;
            $display("FAIL hold_outputs: caddr=%h daddr=%h ddata=%h, required 0011 0022 1_2_3", oCodeAddress, oDataAddress, oDataData);
        end
    endtask

    task automatic test_not_selected();
        CYC_I = 1'b1; WE_I = 1'b0; STB_I = 1'b1; TAG_I = TAG_DATA_ADDRESS_TYPE; ADR_I = 32'h55; DAT_I = 32'hDEAD;
        for (int i = 0; i < 6; i++) begin
            step();
            tests++;
            if (ACK_O !== 1'b0 || oBusy !== 1'b0) begin
                fails++;
                $display("FAIL not_selected: ack=%b busy=%b, required 0 0", ACK_O, oBusy);
            end
        end
        CYC_I = 1'b0; STB_I = 1'b0;
        step();
    endtask

    task automatic test_early_abort();
        send_block(TAG_DATA_ADDRESS_TYPE, 32'h33, 32'hCAFE0001, 32'd0, 32'd0, 1);
        tests++;
        if (oProtocolError !== 1'b1 || oBusy !== 1'b0 || oDataAddress !== 16'h0022) begin
            fails++;
            $display("FAIL early_abort: err=%b busy=%b daddr=%h, required 1 0 0022", oProtocolError, oBusy, oDataAddress);
        end
        push(1'b0, 16'h0034, 96'h0000000A_0000000B_0000000C);
        send_block(TAG_DATA_ADDRESS_TYPE, 32'h34, 32'hA, 32'hB, 32'hC, 3);
        tests++;
        if (exp_q.size() !== 0 || oProtocolError !== 1'b1) begin
            fails++;
            $display("FAIL after_abort: pending=%0d err=%b, required 0 1", exp_q.size(), oProtocolError);
        end
    endtask

    task automatic test_reset_mid_block();
        bit got;
        CYC_I = 1'b1; WE_I = 1'b1; TAG_I = TAG_INSTRUCTION_ADDRESS_TYPE; ADR_I = 32'h77;
        DAT_I = 32'h99990001; STB_I = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (ACK_O === 1'b1) got = 1'b1;
        end
        tests++;
        if (!got || oBusy !== 1'b1) begin
            fails++;
            $display("FAIL mid_block_setup: ack_seen=%b busy=%b, required 1 1", got, oBusy);
        end
        #2 Reset = 1'b0;
        #1;
        tests++;
        if ({ACK_O, oCodeWriteEnable, oDataWriteEnable, oBusy, oProtocolError} !== 5'b0 ||
            oCodeData !== 64'd0 || oCodeAddress !== 16'd0 || oDataData !== 96'd0) begin
            fails++;
            $display("FAIL async_reset: ack=%b busy=%b err=%b cdata=%h, required all zero", ACK_O, oBusy, oProtocolError, oCodeData);
        end
        CYC_I = 1'b0; WE_I = 1'b0; STB_I = 1'b0;
        step();
        Reset = 1'b1;
        step();
        push(1'b1, 16'h0040, {32'd0, 64'h12345678_9ABCDEF0});
        send_block(TAG_INSTRUCTION_ADDRESS_TYPE, 32'h40, 32'h12345678, 32'h9ABCDEF0, 32'd0, 2);
        tests++;
        if (exp_q.size() !== 0 || oProtocolError !== 1'b0) begin
            fails++;
            $display("FAIL after_reset_block: pending=%0d err=%b, required 0 0", exp_q.size(), oProtocolError);
        end
    endtask

    initial begin
        test_reset();
        test_code_block();
        test_data_block();
        test_back_to_back();
        test_not_selected();
        test_early_abort();
        test_reset_mid_block();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
